// File: rtl/vga_framebuffer.sv
// Downscaled framebuffer feeding the VGA timing stage: 1-cycle registered pixel read, write port ready only in IDLE, and a DEPTH-cycle clear engine.
// Define TEST_PATTERN_EN to add an 8-bar colour test pattern selected by test_mode.
module vga_framebuffer #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       pos_x,
    input  logic [8:0]       pos_y,
    output logic [PIX_W-1:0] pixel_out,
    output logic             frame_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_x,
    input  logic [6:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_oob,
    input  logic             clr_req,
    input  logic [PIX_W-1:0] clr_color,
    output logic             busy,
    output logic             clr_done,
    input  logic             test_mode
);
    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state, stateNext;
    logic [ADDR_W-1:0]  clrCnt;
    logic [PIX_W-1:0]   clrColor;
    logic [PIX_W-1:0]   mem [DEPTH];

    logic               inView;
    logic [ADDR_W-1:0]  rdAddr;
    logic [PIX_W-1:0]   memRd;
    logic [PIX_W-1:0]   pixSel;

    logic               wrFire;
    logic               wrInRange;
    logic [ADDR_W-1:0]  wrAddr;
    logic               memWe;
    logic [ADDR_W-1:0]  memAddr;
    logic [PIX_W-1:0]   memData;

    // Blanking positions are steered to address 0 so the read never leaves the array.
    assign inView = (pos_x < 10'd640) && (pos_y < 9'd480);
    always_comb begin
        rdAddr = '0;
        if (inView)
            rdAddr = ADDR_W'(pos_y >> SCALE_SH) * ADDR_W'(FB_W) + ADDR_W'(pos_x >> SCALE_SH);
    end
    assign memRd = mem[rdAddr];

`ifdef TEST_PATTERN_EN
    logic [2:0]       barIdx;
    logic [PIX_W-1:0] barColor;
    assign barIdx = 3'(pos_x / 10'd80);
    always_comb begin
        barColor = '0;
        case (barIdx)
            3'd0: barColor = PIX_W'(12'hFFF);
            3'd1: barColor = PIX_W'(12'hFF0);
            3'd2: barColor = PIX_W'(12'h0FF);
            3'd3: barColor = PIX_W'(12'h0F0);
            3'd4: barColor = PIX_W'(12'hF0F);
            3'd5: barColor = PIX_W'(12'hF00);
            3'd6: barColor = PIX_W'(12'h00F);
            default: barColor = PIX_W'(12'h000);
        endcase
    end
    assign pixSel = test_mode ? barColor : memRd;
`else
    logic unusedTestMode;
    assign unusedTestMode = test_mode;
    assign pixSel = memRd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out   <= '0;
            frame_start <= 1'b0;
        end else begin
            pixel_out   <= inView ? pixSel : '0;
            frame_start <= (pos_x == 10'd0) && (pos_y == 9'd0);
        end
    end

    assign wr_ready  = (state == IDLE) && !rst;
    assign busy      = (state == CLEAR);
    assign wrFire    = wr_valid && wr_ready;
    assign wrInRange = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
    assign wrAddr    = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);

    always_comb begin
        stateNext = state;
        memWe     = 1'b0;
        memAddr   = wrAddr;
        memData   = wr_data;
        case (state)
            IDLE: begin
                memWe = wrFire && wrInRange;
                if (clr_req)
                    stateNext = CLEAR;
            end
            CLEAR: begin
                memWe   = !rst;
                memAddr = clrCnt;
                memData = clrColor;
                if (clrCnt == LAST_ADDR)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clrCnt   <= '0;
            clrColor <= '0;
            wr_oob   <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= stateNext;
            wr_oob   <= wrFire && !wrInRange;
            clr_done <= (state == CLEAR) && (clrCnt == LAST_ADDR);
            if (state == IDLE && clr_req) begin
                clrColor <= clr_color;
                clrCnt   <= '0;
            end else if (state == CLEAR) begin
                clrCnt   <= clrCnt + 1'b1;
            end
        end
    end

    // Memory has no reset; the registered read above samples the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (memWe)
            mem[memAddr] <= memData;
    end
endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed-vector bench for vga_framebuffer: read latency/tiling, blanking, out-of-range writes, clear and reset-during-clear.
module tb_vga_framebuffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [11:0] pixel_out;
    logic        frame_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        wr_oob;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        busy;
    logic        clr_done;
    logic        test_mode;

    int checkCnt = 0;
    int errCnt   = 0;

    vga_framebuffer dut (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .pixel_out(pixel_out), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_oob(wr_oob), .clr_req(clr_req), .clr_color(clr_color),
        .busy(busy), .clr_done(clr_done), .test_mode(test_mode)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fbWrite(input int x, input int y, input logic [11:0] d);
        wr_x = 8'(x); wr_y = 7'(y); wr_data = d; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic readCheck(input string tag, input int px, input int py, input logic [11:0] exp);
        pos_x = 10'(px); pos_y = 9'(py);
        tick();
        check(tag, 32'(pixel_out), 32'(exp));
    endtask

    initial begin
        int n, wrBad, doneCnt, scanErr;
        rst = 1'b1; pos_x = 10'd700; pos_y = 9'd0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
        wr_data = '0; clr_req = 1'b0; clr_color = '0; test_mode = 1'b0;
        repeat (3) tick();
        check("rst_pixel", 32'(pixel_out), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_oob", 32'(wr_oob), 0);
        check("rst_clr_done", 32'(clr_done), 0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", 32'(wr_ready), 1);

        fbWrite(0, 0, 12'h111);
        fbWrite(0, 1, 12'h333);
        fbWrite(159, 119, 12'h222);
        fbWrite(2, 2, 12'h456);
        fbWrite(4, 2, 12'h123);
        fbWrite(3, 2, 12'hABC);
        for (int py = 8; py <= 11; py++)
            for (int px = 12; px <= 15; px++)
                readCheck($sformatf("tile_%0d_%0d", px, py), px, py, 12'hABC);
        readCheck("tile_right_nb", 16, 8, 12'h123);
        readCheck("tile_left_nb", 11, 9, 12'h456);

        readCheck("blank_x640", 640, 0, 12'h000);
        readCheck("blank_y480", 0, 480, 12'h000);
        pos_x = 10'd5; pos_y = 9'd5; tick();
        check("fs_idle", 32'(frame_start), 0);
        pos_x = 10'd0; pos_y = 9'd0; tick();
        check("fs_pulse", 32'(frame_start), 1);
        check("pix_origin", 32'(pixel_out), 32'h111);
        pos_x = 10'd1; tick();
        check("fs_end", 32'(frame_start), 0);

        wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_data = 12'hEEE;
        tick();
        check("oob_ready_x", 32'(wr_ready), 1);
        check("oob_pulse_x", 32'(wr_oob), 1);
        wr_x = 8'd0; wr_y = 7'd120;
        tick();
        check("oob_pulse_y", 32'(wr_oob), 1);
        wr_valid = 1'b0;
        tick();
        check("oob_clear", 32'(wr_oob), 0);
        readCheck("oob_keep_00", 0, 0, 12'h111);
        readCheck("oob_keep_01", 0, 4, 12'h333);
        readCheck("oob_keep_last", 636, 476, 12'h222);

        clr_color = 12'h0F0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0; wrBad = 0; doneCnt = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            if (wr_ready !== 1'b0) wrBad++;
            if (clr_done !== 1'b0) doneCnt++;
            clr_req = (n == 100);
            if (n == 100) clr_color = 12'hF00;
            tick();
        end
        check("clr_busy_cycles", 32'(n), 19200);
        check("clr_wr_ready_low", 32'(wrBad), 0);
        check("clr_done_early", 32'(doneCnt), 0);
        check("clr_done_pulse", 32'(clr_done), 1);
        check("clr_ready_back", 32'(wr_ready), 1);
        tick();
        check("clr_done_single", 32'(clr_done), 0);
        check("clr_idle", 32'(busy), 0);

        scanErr = 0;
        for (int by = 0; by < 120; by++)
            for (int bx = 0; bx < 160; bx++) begin
                pos_x = 10'(bx * 4 + bx % 4);
                pos_y = 9'(by * 4 + by % 4);
                tick();
                if (pixel_out !== 12'h0F0) scanErr++;
            end
        check("clr_scan_errors", 32'(scanErr), 0);

        fbWrite(159, 119, 12'hABC);
        clr_color = 12'h00F; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5000) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready_in_rst", 32'(wr_ready), 0);
        rst = 1'b0;
        tick();
        check("midrst_ready", 32'(wr_ready), 1);
        check("midrst_idle", 32'(busy), 0);
        readCheck("midrst_a4999", 156, 124, 12'h00F);
        readCheck("midrst_a5001", 164, 124, 12'h0F0);
        readCheck("midrst_a19199", 636, 476, 12'hABC);

        test_mode = 1'b1;
`ifdef TEST_PATTERN_EN
        readCheck("bar_x0", 0, 10, 12'hFFF);
        readCheck("bar_x79", 79, 10, 12'hFFF);
        readCheck("bar_x80", 80, 10, 12'hFF0);
        readCheck("bar_x400", 400, 10, 12'hF00);
        readCheck("bar_x639", 639, 10, 12'h000);
        readCheck("bar_blank", 640, 10, 12'h000);
`else
        readCheck("tm_ignored", 0, 0, 12'h00F);
`endif
        test_mode = 1'b0;
        readCheck("tm_off_fb", 0, 0, 12'h00F);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end
endmodule
